// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command assembler
//
// Holds the assembler state encoding, the byte width and the default
// parameter values used by uart_cmd_asm and uart_idle_timer.
`timescale 1ns/1ps

package uart_cmd_pkg;

  localparam int BYTE_W             = 8;
  localparam int NUM_BYTES_DEF      = 3;
  localparam int TIMEOUT_CYCLES_DEF = 104166;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - idle-cycle counter with single-cycle expiry flag
//
// Counts clocks while enable is high and clear is low. expire is high in the
// cycle where the count sits at TIMEOUT_CYCLES-1, unless clear is also high
// that cycle (a fresh event always beats the timeout).
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   clear   in   restart the count from 0
//   enable  in   count only while high; count held at 0 otherwise
//   expire  out  combinational expiry indication
`timescale 1ns/1ps

module uart_idle_timer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Saturates at LAST so a held-off expiry never wraps back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable & ~clear & (cnt == LAST);

endmodule

// File: rtl/uart_cmd_asm.sv
// rtl/uart_cmd_asm.sv - packs NUM_BYTES UART bytes (MSB first) into one command word
//
// Optional feature macro: UART_CMD_TIMEOUT_EN (inter-byte idle timeout that
// aborts a partial command and pulses timeout_err).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   rx_data[7:0] in   byte from UART_rx
//   rx_rdy       in   UART_rx byte valid, level until cleared
//   clr_rx_rdy   out  combinational capture strobe back to UART_rx clr_rdy
//   cmd          out  assembled command, first byte in MSBs
//   cmd_rdy      out  command valid, level
//   clr_cmd_rdy  in   consumer acknowledge
//   timeout_err  out  one-cycle pulse on partial-command abort (0 without macro)
`timescale 1ns/1ps

module uart_cmd_asm
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES      = NUM_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          rx_rdy,
  output logic                          clr_rx_rdy,
  output logic [BYTE_W*NUM_BYTES-1:0]   cmd,
  output logic                          cmd_rdy,
  input  logic                          clr_cmd_rdy,
  output logic                          timeout_err
);

  localparam int CMD_W = BYTE_W * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

  if (NUM_BYTES < 2 || NUM_BYTES > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_cmd_asm: NUM_BYTES must be 2..4 and TIMEOUT_CYCLES >= 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             capture;
  logic             last_byte;
  logic             expire;

  // A pending acknowledge takes priority over a new byte; the byte simply
  // waits in UART_rx for one more cycle.
  assign capture   = rx_rdy & (state != FULL) & ~clr_cmd_rdy;
  assign last_byte = capture & (count == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (capture) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (last_byte)   state_nxt = FULL;
        else if (expire) state_nxt = IDLE;
      end
      FULL: begin
        if (clr_cmd_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; the strobe is gated by reset so UART_rx is never cleared while
  // the assembler is being reset.
  always_comb begin
    cmd_rdy    = (state == FULL);
    clr_rx_rdy = rst_n & capture;
  end

  // Byte counter and shift register. cmd is left untouched on acknowledge so
  // the consumer may keep reading it until the next byte arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      cmd   <= '0;
    end else if (capture) begin
      cmd   <= {cmd[CMD_W-BYTE_W-1:0], rx_data};
      count <= last_byte ? '0 : count + CNT_W'(1);
    end else if (expire) begin
      count <= '0;
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  logic coll;

  assign coll = (state == COLLECT);

  uart_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (capture),
    .enable (coll),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_asm.sv
// tb/tb_uart_cmd_asm.sv - self-checking scoreboard bench for uart_cmd_asm
`timescale 1ns/1ps

module tb_uart_cmd_asm;

  localparam int NB = 3;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        timeout_err;

  int          n_err = 0;
  int          n_chk = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_acc = '0;
  int          exp_n = 0;
  int          strobes = 0;
  int          tout_pulses = 0;
  int          t0;
  logic        cmd_rdy_d = 1'b0;

  uart_cmd_asm #(
    .NUM_BYTES      (NB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void note_byte(input logic [7:0] b);
    exp_acc = {exp_acc[15:0], b};
    exp_n++;
    if (exp_n == NB) begin
      exp_q.push_back(exp_acc);
      exp_n = 0;
    end
  endfunction

  // Scoreboard side: strobe and timeout counters, command compare on rising cmd_rdy.
  always @(negedge clk) begin
    if (clr_rx_rdy) strobes++;
    if (timeout_err) tout_pulses++;
    if (cmd_rdy && !cmd_rdy_d) begin
      if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
      else check("cmd", {8'h00, cmd}, {8'h00, exp_q.pop_front()});
    end
    cmd_rdy_d = cmd_rdy;
  end

  // UART_rx model: hold rdy until the strobe, drop it after the capture edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    while (!clr_rx_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!clr_rx_rdy) check("strobe_timeout", 0, 1);
    else note_byte(b);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    check("cmd_rdy_clr", cmd_rdy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a byte already pending: no strobe may escape.
    rx_data = 8'hEE;
    rx_rdy  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_clr_rx_rdy", clr_rx_rdy, 0);
    end
    check("rst_cmd", cmd, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    rst_n  = 1'b1;

    // Basic three-byte command and latency of cmd_rdy.
    send_byte(8'hA5);
    send_byte(8'h5A);
    check("cmd_rdy_early", cmd_rdy, 0);
    send_byte(8'h0F);
    check("cmd_rdy_latency", cmd_rdy, 1);
    check("strobes_t1", strobes, 3);

    // Back-pressure while FULL, then ack and byte in the same cycle.
    rx_data = 8'h33;
    rx_rdy  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_no_strobe", clr_rx_rdy, 0);
      check("bp_cmd_frozen", cmd, 24'hA55A0F);
    end
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(negedge clk);
    check("ack_blocks_capture", clr_rx_rdy, 0);
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    check("ack_cmd_rdy_fall", cmd_rdy, 0);
    check("ack_cmd_kept", cmd, 24'hA55A0F);
    @(negedge clk);
    check("deferred_strobe", clr_rx_rdy, 1);
    note_byte(8'h33);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    check("deferred_capture", cmd, 24'h5A0F33);
    send_byte(8'h77);
    send_byte(8'h88);
    check("strobes_t2", strobes, 6);
    ack();

    // Acknowledge while collecting only delays the byte by one cycle.
    send_byte(8'h12);
    clr_cmd_rdy = 1'b1;
    rx_data     = 8'h34;
    rx_rdy      = 1'b1;
    @(negedge clk);
    check("collect_ack_block", clr_rx_rdy, 0);
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    send_byte(8'h34);
    send_byte(8'h56);
    ack();

    // Reset mid-command discards the partial word.
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n   = 1'b0;
    rx_data = 8'h99;
    rx_rdy  = 1'b1;
    @(negedge clk);
    check("midrst_no_strobe", clr_rx_rdy, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rx_rdy = 1'b0;
    check("midrst_cmd", cmd, 0);
    check("midrst_cmd_rdy", cmd_rdy, 0);
    exp_n   = 0;
    exp_acc = '0;
    send_byte(8'h44);
    check("no_stale", cmd, 24'h000044);
    send_byte(8'h55);
    send_byte(8'h66);
    ack();

    // Extreme byte values.
    send_byte(8'h00);
    send_byte(8'h76);
    send_byte(8'hFF);
    check("cmd_rdy_t4", cmd_rdy, 1);
    ack();
    check("strobes_total", strobes, 17);

`ifdef UART_CMD_TIMEOUT_EN
    // Single byte then a long idle gap: abort with one timeout pulse.
    t0 = tout_pulses;
    send_byte(8'hAB);
    repeat (60) @(posedge clk);
    #1;
    check("tout_pulse_count", tout_pulses - t0, 1);
    check("tout_no_cmd_rdy", cmd_rdy, 0);
    exp_n   = 0;
    exp_acc = '0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    ack();

    // Gap of exactly TO-1 idle cycles: the capture wins over expiry.
    t0 = tout_pulses;
    send_byte(8'h10);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h20);
    check("gap49_no_tout", tout_pulses - t0, 0);
    send_byte(8'h30);
    check("gap49_cmd_rdy", cmd_rdy, 1);
    ack();
`else
    check("tout_tied_low", tout_pulses, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
